// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac_pkg
//  Description : Shared constants for the DAC code streamer: code width,
//                FIFO depth, divider width, midscale code and synchronizer
//                depth, plus derived pointer/count widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package dac_pkg;

    localparam int              DATA_W      = 8;
    localparam int              DEPTH       = 8;
    localparam int              DIV_W       = 8;
    localparam logic [DATA_W-1:0] MIDSCALE  = 8'h80;
    localparam int              SYNC_STAGES = 2;

    // Pointers wrap naturally; count needs one extra bit to represent DEPTH.
    localparam int              PTR_W       = $clog2(DEPTH);
    localparam int              CNT_W       = PTR_W + 1;

endpackage : dac_pkg
`default_nettype wire

// File: rtl/dac_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dac_sample_fifo
//  Description : Synchronous sample FIFO with push/pop, full/empty and a
//                synchronous flush. Pops on empty and pushes on full (without
//                a same-cycle pop) are ignored; there is no bypass path.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                i_flush         - clear pointers/count (wins over push/pop)
//                i_push, i_data  - write request and data
//                i_pop           - read request; o_head is the oldest entry
//                o_full, o_empty - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_sample_fifo
    import dac_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // A push into a full FIFO is legal only because the same-cycle pop
    // frees the slot the write pointer is about to land on.
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : dac_sample_fifo
`default_nettype wire

// File: rtl/dac_code_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : dac_code_streamer
//  Description : Front end for the R-2R DAC. Host writes (strobed from the
//                pad) either push a sample code into the FIFO or load the
//                sample-period divider. While running, one code per period
//                is popped onto the registered dac_code bus.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                wr_data, wr_strobe  - pad write bus and async strobe
//                wr_sel              - 0 = push sample, 1 = load divider
//                run, clr            - async levels: stream enable, flush
//                dac_code            - registered DAC code
//                sample_tick         - pulse in the cycle dac_code updates
//                fifo_full/empty     - FIFO occupancy
//                underrun/overflow   - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_code_streamer
    import dac_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_strobe,
    input  logic              wr_sel,
    input  logic              run,
    input  logic              clr,
    output logic [DATA_W-1:0] dac_code,
    output logic              sample_tick,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              underrun,
    output logic              overflow
);

    // Strobe chain carries one extra stage beyond the synchronizer so the
    // rising edge can be detected on synchronized values only.
    logic [SYNC_STAGES:0]   r_strobe_sync;
    logic [SYNC_STAGES-1:0] r_run_sync;
    logic [SYNC_STAGES-1:0] r_clr_sync;
    logic [DIV_W-1:0]       r_div;
    logic [DIV_W-1:0]       r_div_cnt;
    logic [DATA_W-1:0]      w_head;
    logic                   w_wr_pulse;
    logic                   w_run_s;
    logic                   w_clr_s;
    logic                   w_div_load;
    logic                   w_push_req;
    logic                   w_tick;
    logic                   w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe_sync <= '0;
            r_run_sync    <= '0;
            r_clr_sync    <= '0;
        end else begin
            r_strobe_sync <= {r_strobe_sync[SYNC_STAGES-1:0], wr_strobe};
            r_run_sync    <= {r_run_sync[SYNC_STAGES-2:0], run};
            r_clr_sync    <= {r_clr_sync[SYNC_STAGES-2:0], clr};
        end
    end

    assign w_wr_pulse = r_strobe_sync[SYNC_STAGES-1] & ~r_strobe_sync[SYNC_STAGES];
    assign w_run_s    = r_run_sync[SYNC_STAGES-1];
    assign w_clr_s    = r_clr_sync[SYNC_STAGES-1];

    // wr_data/wr_sel are held stable by the host well past the pulse, so
    // they are used directly without their own synchronizers.
    assign w_div_load = w_wr_pulse & wr_sel;
    assign w_push_req = w_wr_pulse & ~wr_sel;

    assign w_tick = w_run_s & (r_div_cnt == r_div);
    assign w_pop  = w_tick & ~fifo_empty & ~w_clr_s;

    dac_sample_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_clr_s),
        .i_push  (w_push_req),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Divider register survives a flush; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_div_load) begin
            r_div <= DIV_W'(wr_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (w_clr_s || !w_run_s || w_div_load || (r_div_cnt == r_div)) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_code    <= MIDSCALE;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
            overflow    <= 1'b0;
        end else if (w_clr_s) begin
            dac_code    <= MIDSCALE;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            sample_tick <= w_pop;
            if (w_pop) begin
                dac_code <= w_head;
            end
            if (w_tick && fifo_empty) begin
                underrun <= 1'b1;
            end
            if (w_push_req && fifo_full && !w_pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule : dac_code_streamer
`default_nettype wire

// File: doc/dac_code_streamer.md
Name: dac_code_streamer

Overview:
Digital front end that feeds the on-chip R-2R DAC core of the analog top. It accepts 8-bit sample codes from the pad bus through a strobed write port and buffers them in a small FIFO. It then releases one code per programmable sample period onto the registered DAC code bus. Underrun and overflow are flagged so firmware can pace writes.

Parameters:
DATA_W, 8, DAC code width
DEPTH, 8, FIFO entries; power of two, >=2
DIV_W, 8, sample-period divider width
MIDSCALE, 8'h80, DAC code driven after reset or flush

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wr_data  input  DATA_W  sample code or divider value (from ui_in)
wr_strobe  input  1  asynchronous write strobe from pad; rising edge = write
wr_sel  input  1  0 = push sample, 1 = load divider (sampled with strobe edge)
run  input  1  level; 1 = stream samples to DAC
clr  input  1  level; synchronous flush FIFO and clear sticky flags
dac_code  output  DATA_W  registered code to DAC switches (uo_out)
sample_tick  output  1  one-cycle pulse when dac_code updates
fifo_full  output  1  FIFO count == DEPTH
fifo_empty  output  1  FIFO count == 0
underrun  output  1  sticky: tick with empty FIFO
overflow  output  1  sticky: push rejected while full

Behaviour:
- Reset: clk and rst_n as named; rst_n asynchronous, active-low.
- Reset values: dac_code=MIDSCALE, sample_tick=0, FIFO count/pointers=0 (fifo_empty=1, fifo_full=0), underrun=0, overflow=0, divider register=0, divide counter=0, synchronizers=0.
- wr_strobe, run and clr are each passed through a 2-flop synchronizer.
- Write: a rising edge is detected on the synchronized strobe (sync2 & ~sync3), producing a one-cycle wr_pulse 3 clk edges after the pad edge. wr_data and wr_sel are captured on that cycle; the host holds them stable >=4 clk cycles after raising the strobe.
- wr_pulse with wr_sel=1: divider register <= wr_data. The divide counter restarts at 0 on the next cycle.
- wr_pulse with wr_sel=0: push wr_data.
- Full FIFO: the push is accepted only if a pop occurs in the same cycle. Otherwise the data is dropped and overflow is set.
- Divide counter: counts only while run_s=1. It counts 0..div then wraps to 0; the tick is asserted on the cycle count==div. Period = div+1 clk cycles; div=0 gives a tick every cycle.
- run_s=0: the counter is held at 0, no ticks occur, dac_code holds its value, and writes are still accepted.
- Tick with FIFO non-empty: pop; dac_code <= head entry at the next edge, with sample_tick=1 in that same cycle (latency 1).
- Tick with FIFO empty: dac_code holds, underrun is set, and sample_tick stays 0.
- Simultaneous push and pop at count 0: no bypass. The pop underruns and the pushed data is stored (count becomes 1).
- Same-cycle push and pop when not empty or full: count is unchanged and the pointers both advance.
- Pointer arithmetic: log2(DEPTH)-bit pointers, natural wrap. Count is log2(DEPTH)+1 bits.
- clr_s=1: pointers/count <= 0, underrun <= 0, overflow <= 0, dac_code <= MIDSCALE, divide counter <= 0. This has priority over push/pop/tick in the same cycle. Divider register is kept.
- Sticky flags clear only via clr_s or reset.
- Reset asserted mid-stream: all state returns to reset values immediately; FIFO contents are discarded.

Decomposition:
- Shared package dac_pkg: DATA_W, DIV_W, DEPTH, MIDSCALE, and the sync stage count (2).
- One sub-module: dac_sample_fifo (synchronous FIFO with push/pop, full/empty, count, flush). The synchronizers, edge detect, divider and output register stay in the top.

Test Plan:
- Reset, then idle 10 cycles -> dac_code=8'h80, fifo_empty=1, no sample_tick, flags 0.
- Load divider 3 (wr_sel=1), push 8'h10, 8'h20, 8'h30, then run=1 -> dac_code steps 10,20,30 with sample_tick exactly 4 cycles apart. Next tick sets underrun=1 and dac_code holds 8'h30.
- run=0, push 9 samples with DEPTH=8 -> fifo_full=1 after the 8th push, overflow=1 after the 9th. Then run=1 with div=0 -> 8 consecutive codes, the 9th value never appears.
- div=0, run=1, push 8'hA5 while empty -> first tick after the push pops A5 one cycle later, preceded by underrun on earlier ticks.
- Assert clr for 1 cycle (synchronized) while the FIFO holds 5 entries -> fifo_empty=1, dac_code=8'h80, flags 0, divider value retained.
- Pulse rst_n low asynchronously mid-stream (between clk edges) -> outputs return to reset values immediately without waiting for a clk edge.
